lutnet_table_writer: RTL and testbench

- Runtime-programmable LogicNets neuron: the writer side for a hard-coded truth-table neuron.
- Accepts a serialized truth table over a valid/ready config stream and assembles it in a shadow buffer.
- Commits the table atomically into the active table; serves registered lookups from the active table.
- Sits in the layer wrapper where a fixed neuron ROM would sit, so tables can be swapped without resynthesis.

---
 rtl/lutnet_table_writer.sv | 167 ++++++++++++++++
 tb/tb_lutnet_table_writer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lutnet_table_writer.sv
// lutnet_table_writer: runtime-programmable truth-table neuron.
// A serialized truth table arrives over a valid/ready config stream and is
// assembled in a shadow buffer. A complete, well-framed table is committed
// into the active table in a single cycle. Lookups are registered reads of
// the active table and run independently of configuration.
//
// Optional feature (macro LUT_READBACK_EN): adds a readback port pair
// rb_addr/rb_data that reads the active table with one cycle of latency.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_valid/ready     config word handshake
//   cfg_data, cfg_last  config word (word k = flat bits [k*CFG_W +: CFG_W]), end-of-table marker
//   cfg_err             one-cycle pulse on a framing error
//   cfg_done            one-cycle pulse when a new table becomes active
//   in_valid, in_data   lookup request and address
//   out_valid, out_data lookup result (latency 1)
//   rb_addr, rb_data    readback address/data (LUT_READBACK_EN only)
module lutnet_table_writer #(
  parameter int unsigned IN_BITS    = 6,
  parameter int unsigned OUT_BITS   = 1,
  parameter int unsigned CFG_W      = 8,
  parameter int unsigned RESET_FILL = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_last,
  output logic                cfg_err,
  output logic                cfg_done,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
`ifdef LUT_READBACK_EN
  ,
  input  logic [IN_BITS-1:0]  rb_addr,
  output logic [OUT_BITS-1:0] rb_data
`endif
);

  localparam int unsigned DEPTH  = 2**IN_BITS;
  localparam int unsigned TBL_W  = DEPTH * OUT_BITS;
  localparam int unsigned NWORDS = (TBL_W + CFG_W - 1) / CFG_W;
  localparam int unsigned SHD_W  = NWORDS * CFG_W;
  localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [TBL_W-1:0] FILL = (RESET_FILL != 0) ? {TBL_W{1'b1}} : {TBL_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SHD_W-1:0]   shadow_q;
  logic [TBL_W-1:0]   active_q;
  logic               ready_d, err_d, done_d;
  logic               wr_en_c;
  logic               accept_c;
  logic               is_final_c;

  assign accept_c   = cfg_valid && cfg_ready;
  assign is_final_c = (count_q == CNT_W'(NWORDS - 1));

  // State, counter and handshake/status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      cfg_ready <= ready_d;
      cfg_err   <= err_d;
      cfg_done  <= done_d;
    end
  end

  // Next-state: every accepted word is stored; the word position and
  // cfg_last together decide commit, continue, or framing error.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    wr_en_c = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (accept_c) begin
          wr_en_c = 1'b1;
          if (is_final_c && cfg_last) begin
            state_d = COMMIT;
            count_d = '0;
          end else if (is_final_c || cfg_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
            count_d = '0;
          end else begin
            state_d = LOAD;
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        count_d = '0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    ready_d = (state_d != COMMIT);
  end

  // Shadow buffer assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (wr_en_c) begin
      shadow_q[int'(count_q) * CFG_W +: CFG_W] <= cfg_data;
    end
  end

  // Atomic commit; unused high bits of the last word are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= FILL;
    end else if (state_q == COMMIT) begin
      active_q <= shadow_q[TBL_W-1:0];
    end
  end

  // Lookup pipeline: reads the pre-edge table, so a commit edge still serves old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= active_q[int'(in_data) * OUT_BITS +: OUT_BITS];
      end
    end
  end

`ifdef LUT_READBACK_EN
  // Readback port, same timing as lookup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data <= '0;
    end else begin
      rb_data <= active_q[int'(rb_addr) * OUT_BITS +: OUT_BITS];
    end
  end
`endif

endmodule

// File: tb/tb_lutnet_table_writer.sv
// Directed bench for lutnet_table_writer (default parameters: 64x1 table, 8-bit config words).
module tb_lutnet_table_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       cfg_err;
  logic       cfg_done;
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_valid;
  logic [0:0] out_data;
`ifdef LUT_READBACK_EN
  logic [5:0] rb_addr;
  logic [0:0] rb_data;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] addr;
    logic       exp;
  } vec_t;

  vec_t va5[7];
  vec_t vinc[8];

  always #5 clk = ~clk;

  lutnet_table_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_err   (cfg_err),
    .cfg_done  (cfg_done),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef LUT_READBACK_EN
    ,
    .rb_addr   (rb_addr),
    .rb_data   (rb_data)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_word(input logic [7:0] d, input logic l);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic load_const(input logic [7:0] d, input string name);
    for (int k = 0; k < 8; k++) cfg_word(d, k == 7);
    chk({name, "_commit_ready"}, 32'(cfg_ready), 32'd0);
    chk({name, "_err"}, 32'(cfg_err), 32'd0);
    step();
    chk({name, "_done"}, 32'(cfg_done), 32'd1);
    chk({name, "_ready_back"}, 32'(cfg_ready), 32'd1);
    step();
    chk({name, "_done_clear"}, 32'(cfg_done), 32'd0);
  endtask

  task automatic lookup(input logic [5:0] a, input logic exp, input string name);
    in_valid = 1'b1;
    in_data  = a;
    step();
    in_valid = 1'b0;
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk($sformatf("%s_data@%0d", name, a), 32'(out_data), 32'(exp));
  endtask

  initial begin
    // 0xA5 in every word: bits 0,2,5,7 set within each byte
    va5[0] = '{6'd0,  1'b1};
    va5[1] = '{6'd1,  1'b0};
    va5[2] = '{6'd2,  1'b1};
    va5[3] = '{6'd5,  1'b1};
    va5[4] = '{6'd8,  1'b1};
    va5[5] = '{6'd14, 1'b0};
    va5[6] = '{6'd63, 1'b1};
    // word k = k+1
    vinc[0] = '{6'd0,  1'b1};
    vinc[1] = '{6'd1,  1'b0};
    vinc[2] = '{6'd8,  1'b0};
    vinc[3] = '{6'd9,  1'b1};
    vinc[4] = '{6'd16, 1'b1};
    vinc[5] = '{6'd17, 1'b1};
    vinc[6] = '{6'd56, 1'b0};
    vinc[7] = '{6'd59, 1'b1};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    in_valid = 1'b0; in_data = '0;
`ifdef LUT_READBACK_EN
    rb_addr = '0;
`endif
    step();
    step();
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(cfg_ready), 32'd1);
    lookup(6'h15, 1'b0, "rst_lookup");
    step();
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // A5 table
    load_const(8'hA5, "a5");
    for (int i = 0; i < 7; i++) lookup(va5[i].addr, va5[i].exp, "a5");
    step();
    chk("hold_valid", 32'(out_valid), 32'd0);
    chk("hold_data", 32'(out_data), 32'(va5[6].exp));

    // early cfg_last on word 3
    for (int k = 0; k < 3; k++) cfg_word(8'h00, 1'b0);
    cfg_word(8'h00, 1'b1);
    chk("early_last_err", 32'(cfg_err), 32'd1);
    chk("early_last_done", 32'(cfg_done), 32'd0);
    chk("early_last_ready", 32'(cfg_ready), 32'd1);
    step();
    chk("early_last_err_clear", 32'(cfg_err), 32'd0);
    lookup(6'd0, 1'b1, "prior_tbl");
    lookup(6'd1, 1'b0, "prior_tbl");
    lookup(6'd5, 1'b1, "prior_tbl");

    // missing cfg_last
    for (int k = 0; k < 7; k++) begin
      cfg_word(8'hFF, 1'b0);
      chk($sformatf("nolast_err_w%0d", k), 32'(cfg_err), 32'd0);
    end
    cfg_word(8'hFF, 1'b0);
    chk("nolast_err_w7", 32'(cfg_err), 32'd1);
    chk("nolast_done", 32'(cfg_done), 32'd0);
    step();
    lookup(6'd1, 1'b0, "nolast_prior");
    load_const(8'hFF, "ff");
    for (int a = 0; a < 64; a++) lookup(6'(a), 1'b1, "ff");

    // lookups every cycle across a 0 -> 1 commit
    load_const(8'h00, "zero");
    in_valid = 1'b1;
    in_data  = 6'h2A;
    for (int k = 0; k < 8; k++) begin
      cfg_word(8'hFF, k == 7);
      chk($sformatf("stream_data_w%0d", k), 32'(out_data), 32'd0);
      chk($sformatf("stream_ready_w%0d", k), 32'(cfg_ready), (k == 7) ? 32'd0 : 32'd1);
    end
    step();
    chk("collision_old", 32'(out_data), 32'd0);
    chk("collision_done", 32'(cfg_done), 32'd1);
    chk("collision_ready", 32'(cfg_ready), 32'd1);
    step();
    chk("collision_new", 32'(out_data), 32'd1);
    chk("collision_valid", 32'(out_valid), 32'd1);
    chk("collision_done_clear", 32'(cfg_done), 32'd0);
    in_valid = 1'b0;
    step();

    // reset in the middle of a load (table currently all ones)
    for (int k = 0; k < 4; k++) cfg_word(8'h00, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_ready", 32'(cfg_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_ready_back", 32'(cfg_ready), 32'd1);
    for (int a = 0; a < 64; a += 7) lookup(6'(a), 1'b0, "midrst");
    for (int k = 0; k < 8; k++) begin
      cfg_word(8'(k + 1), k == 7);
      chk($sformatf("inc_err_w%0d", k), 32'(cfg_err), 32'd0);
    end
    step();
    chk("inc_done", 32'(cfg_done), 32'd1);
    for (int i = 0; i < 8; i++) lookup(vinc[i].addr, vinc[i].exp, "inc");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
